// File: rtl/axi4_lite_master.sv
// AXI4-Lite master with one transaction outstanding: a command in, one AXI transaction, one rsp_valid pulse back.
// Optional per-phase watchdog is compiled in with `define AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // command side
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_wstrb,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic [1:0]           rsp_resp,
  // write address / data / response
  output logic [ADDR_BITS-1:0] m_axi_awaddr,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  // read address / data
  output logic [ADDR_BITS-1:0] m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t               r_state,     w_state;
  logic [ADDR_BITS-1:0] r_addr,      w_addr;
  logic [31:0]          r_wdata,     w_wdata;
  logic [3:0]           r_wstrb,     w_wstrb;
  logic                 r_awvalid,   w_awvalid;
  logic                 r_wvalid,    w_wvalid;
  logic                 r_arvalid,   w_arvalid;
  logic                 r_rsp_valid, w_rsp_valid;
  logic [31:0]          r_rsp_rdata, w_rsp_rdata;
  logic [1:0]           r_rsp_resp,  w_rsp_resp;

`ifdef AXI_MASTER_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1; the state is left on that cycle.
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_state != IDLE) && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_tmo_cnt <= '0;
    else if (w_state != r_state) r_tmo_cnt <= '0;
    else if (r_state != IDLE)   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  // TIMEOUT_CYCLES has no effect when the watchdog is compiled out.
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_awvalid   <= w_awvalid;
      r_wvalid    <= w_wvalid;
      r_arvalid   <= w_arvalid;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_resp  <= w_rsp_resp;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_awvalid   = r_awvalid;
    w_wvalid    = r_wvalid;
    w_arvalid   = r_arvalid;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_resp  = r_rsp_resp;

    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_addr  = cmd_addr;
          w_wdata = cmd_wdata;
          w_wstrb = cmd_wstrb;
          if (cmd_write) begin
            w_state   = WR_REQ;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
          end else begin
            w_state   = RD_REQ;
            w_arvalid = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once neither is pending.
        if (m_axi_awready) w_awvalid = 1'b0;
        if (m_axi_wready)  w_wvalid  = 1'b0;
        if (!w_awvalid && !w_wvalid) w_state = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          w_state     = IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_resp  = m_axi_bresp;
          w_rsp_rdata = '0;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          w_arvalid = 1'b0;
          w_state   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          w_state     = IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_resp  = m_axi_rresp;
          w_rsp_rdata = m_axi_rdata;
        end
      end
      default: w_state = IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // A phase that completes on its last allowed cycle wins over the timeout.
    if (w_tmo_hit && (w_state == r_state)) begin
      w_state     = IDLE;
      w_awvalid   = 1'b0;
      w_wvalid    = 1'b0;
      w_arvalid   = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_resp  = 2'b11;
      w_rsp_rdata = '0;
    end
`endif
  end

  assign cmd_ready     = (r_state == IDLE);
  assign m_axi_bready  = (r_state == WR_RESP);
  assign m_axi_rready  = (r_state == RD_DATA);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_arvalid = r_arvalid;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;

endmodule
